// File: rtl/gf256_pkg.sv
// Shared GF(2^8) constants, the xtime primitive and the multiplier FSM state type.
package gf256_pkg;

    localparam logic [7:0] GF_POLY_AES = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } gf_state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] x, input logic [7:0] poly);
        return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
    endfunction

    // Number of BUSY cycles for a full byte of b; guarded so a bad width
    // still elaborates far enough to reach the parameter check.
    function automatic int gf_cycles(input int bits_per_cycle);
        return (bits_per_cycle > 0) ? (8 / bits_per_cycle) : 1;
    endfunction

endpackage

// File: rtl/gf256_mul_step.sv
// One shift-and-add step of a GF(2^8) multiply: consume b[0], advance a by xtime.
// Purely combinational; chained BITS_PER_CYCLE deep inside each lane.
module gf256_mul_step
    import gf256_pkg::*;
#(
    parameter logic [7:0] POLY = GF_POLY_AES
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] p,
    output logic [7:0] a_next,
    output logic [7:0] b_next,
    output logic [7:0] p_next
);

    assign p_next = b[0] ? (p ^ a) : p;
    assign a_next = gf_xtime(a, POLY);
    assign b_next = {1'b0, b[7:1]};

endmodule

// File: rtl/gf256_mul_iter.sv
// Iterative N_LANES x GF(2^8) multiplier, BITS_PER_CYCLE bits of b per clock; optional GF_MUL_ACC_EN running XOR accumulator.
// Latency: out_valid rises 8/BITS_PER_CYCLE cycles after the accept edge; one op per 8/BITS_PER_CYCLE+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready is low in BUSY and DONE.
module gf256_mul_iter
    import gf256_pkg::*;
#(
    parameter int         N_LANES        = 4,
    parameter int         BITS_PER_CYCLE = 1,
    parameter logic [7:0] POLY           = GF_POLY_AES
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef GF_MUL_ACC_EN
    input  logic                   acc_clr,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*N_LANES-1:0]   in_a,
    input  logic [8*N_LANES-1:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*N_LANES-1:0]   out_p
);

    localparam int         W      = 8 * N_LANES;
    localparam int         CYCLES = gf_cycles(BITS_PER_CYCLE);
    localparam logic [3:0] LAST   = 4'(CYCLES - 1);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
          BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
        $error("gf256_mul_iter: BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end
    if (N_LANES < 1 || N_LANES > 16) begin : g_bad_lanes
        $error("gf256_mul_iter: N_LANES must be in 1..16");
    end

    gf_state_t      state, state_next;
    logic [W-1:0]   a_r, b_r, p_r, out_p_r;
    logic [W-1:0]   a_step, b_step, p_step;
    logic [W-1:0]   acc_view;
    logic [3:0]     count;
    logic           accept, finish, handoff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (count == LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept  = (state == IDLE) && in_valid;
    assign finish  = (state == BUSY) && (count == LAST);
    assign handoff = (state == DONE) && out_ready;

    // Each lane runs its own unrolled chain; nothing crosses a byte boundary.
    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        for (genvar s = 0; s < BITS_PER_CYCLE; s++) begin : g_step
            logic [7:0] a_i, b_i, p_i, a_o, b_o, p_o;
            if (s == 0) begin : g_head
                assign a_i = a_r[8*l +: 8];
                assign b_i = b_r[8*l +: 8];
                assign p_i = p_r[8*l +: 8];
            end else begin : g_link
                assign a_i = g_step[s-1].a_o;
                assign b_i = g_step[s-1].b_o;
                assign p_i = g_step[s-1].p_o;
            end
            gf256_mul_step #(.POLY(POLY)) u_step (
                .a      (a_i),
                .b      (b_i),
                .p      (p_i),
                .a_next (a_o),
                .b_next (b_o),
                .p_next (p_o)
            );
        end
        assign a_step[8*l +: 8] = g_step[BITS_PER_CYCLE-1].a_o;
        assign b_step[8*l +: 8] = g_step[BITS_PER_CYCLE-1].b_o;
        assign p_step[8*l +: 8] = g_step[BITS_PER_CYCLE-1].p_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            p_r   <= '0;
            count <= '0;
        end else if (accept) begin
            a_r   <= in_a;
            b_r   <= in_b;
            p_r   <= '0;
            count <= '0;
        end else if (state == BUSY) begin
            a_r   <= a_step;
            b_r   <= b_step;
            p_r   <= p_step;
            count <= count + 4'd1;
        end
    end

`ifdef GF_MUL_ACC_EN
    logic [W-1:0] acc_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           acc_r <= '0;
        else if (handoff)                     acc_r <= acc_r ^ p_r;
        else if ((state == IDLE) && acc_clr)  acc_r <= '0;
    end

    assign acc_view = acc_r;
`else
    assign acc_view = '0;
`endif

    // Separate output register so the result survives the next accept
    // clearing p_r, and so a partial product is never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      out_p_r <= '0;
        else if (finish) out_p_r <= acc_view ^ p_step;
    end

    assign out_p = out_p_r;

endmodule
